mem_port_arbiter: RTL

Shares one single-ported memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage pipeline. The block sits between the two pipeline memory ports and a unified memory with a request/ready/response handshake. It serialises transactions with data-over-fetch priority and bounded anti-starvation. The pipeline stalls a stage until that stage's response arrives.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data
// ports; data-over-fetch priority with a bounded data streak.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   if_req/if_addr      fetch request (held until if_gnt)
//   if_gnt/if_rvalid    fetch accept pulse / response pulse, if_rdata
//   dm_req/dm_we/dm_size/dm_addr/dm_wdata   data request (held until dm_gnt)
//   dm_gnt/dm_rvalid    data accept pulse / response pulse, dm_rdata
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata  latched memory request
//   mem_ready, mem_rvalid, mem_rdata             memory handshake/response
//   busy                not idle
//   err                 sticky protocol error
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic [1:0] STREAK_MAX = 2'(MAX_DM_STREAK);

    state_e              state_q, state_d;
    logic [1:0]          streak_q, streak_d;
    // owner: 1 = data port, 0 = fetch port
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                win_dm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // Data wins unless fetch is waiting and data already had its streak.
    assign win_dm = dm_req && (!if_req || streak_q < STREAK_MAX);

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;

        // A response with nothing outstanding is dropped and flagged.
        if (mem_rvalid && state_q != WAIT) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // Grants are suppressed while reset is held low.
                if (rst_n && win_dm) begin
                    dm_gnt   = 1'b1;
                    owner_d  = 1'b1;
                    we_d     = dm_we;
                    size_d   = dm_size;
                    addr_d   = dm_addr;
                    wdata_d  = dm_wdata;
                    streak_d = if_req ? streak_q + 2'd1 : 2'd0;
                    state_d  = ISSUE;
                    if (dm_size == 2'd3) begin
                        err_d = 1'b1;
                    end
                end else if (rst_n && if_req) begin
                    if_gnt   = 1'b1;
                    owner_d  = 1'b0;
                    we_d     = 1'b0;
                    size_d   = 2'd2;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    streak_d = 2'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if_rvalid = !owner_q;
                    dm_rvalid = owner_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule
